// File: rtl/eth_tx_arbiter.sv
// Transmit arbiter that gives the single GMII port to either the ARP or the UDP engine.
// Optional boot-time ARP request is built only when ARP_BOOT_REQ_EN is defined.
module eth_tx_arbiter #(
  parameter int IFG_CYCLES = 12,
  parameter int TX_TIMEOUT = 4095
`ifdef ARP_BOOT_REQ_EN
  ,
  parameter int BOOT_DELAY = 125000
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       arp_rx_done,
  input  logic       arp_rx_type,
  output logic       arp_tx_en,
  output logic       arp_tx_type,
  input  logic       arp_tx_done,
  input  logic       arp_gmii_tx_en,
  input  logic [7:0] arp_gmii_txd,
  input  logic       udp_tx_start_en,
  input  logic       udp_tx_done,
  input  logic       udp_gmii_tx_en,
  input  logic [7:0] udp_gmii_txd,
  output logic       udp_tx_ready,
  output logic       gmii_tx_en,
  output logic [7:0] gmii_txd,
  output logic [1:0] tx_error
);

  localparam int CNT_MAX = (TX_TIMEOUT > IFG_CYCLES) ? TX_TIMEOUT : IFG_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_ARP, S_UDP, S_GAP} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             arp_pend_q;
  logic             arp_tx_en_q;
  logic             arp_tx_type_q;
  logic             gmii_tx_en_q;
  logic [7:0]       gmii_txd_q;
  logic [1:0]       tx_error_q;

  logic             gmii_tx_en_d;
  logic [7:0]       gmii_txd_d;
  logic             arp_req;
  logic             udp_take;
  logic             arp_take;
  logic             boot_take;
  logic             owner_done;
  logic             timeout;

  assign udp_tx_ready = (state_q == S_IDLE);
  assign arp_req      = arp_rx_done & ~arp_rx_type;
  assign udp_take     = udp_tx_ready & udp_tx_start_en;
  assign arp_take     = udp_tx_ready & ~udp_tx_start_en & arp_pend_q;
  assign owner_done   = ((state_q == S_ARP) & arp_tx_done) | ((state_q == S_UDP) & udp_tx_done);
  assign timeout      = (cnt_q == CNT_W'(TX_TIMEOUT - 1));

  // The UDP byte is forwarded in the very cycle its start is accepted.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    gmii_tx_en_d = 1'b0;
    gmii_txd_d   = 8'h00;
    if (state_q == S_ARP) begin
      gmii_tx_en_d = arp_gmii_tx_en;
      gmii_txd_d   = arp_gmii_txd;
    end else if ((state_q == S_UDP) || udp_take) begin
      gmii_tx_en_d = udp_gmii_tx_en;
      gmii_txd_d   = udp_gmii_txd;
    end
  end

`ifdef ARP_BOOT_REQ_EN
  localparam int BOOT_W = $clog2(BOOT_DELAY + 1);

  logic [BOOT_W-1:0] boot_cnt_q;
  logic              boot_fired_q;
  logic              boot_pend_q;

  // A pending reply outranks the boot request; the request waits for a later IDLE.
  assign boot_take = udp_tx_ready & ~udp_tx_start_en & ~arp_pend_q & boot_pend_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      boot_cnt_q   <= '0;
      boot_fired_q <= 1'b0;
      boot_pend_q  <= 1'b0;
    end else begin
      if (!boot_fired_q) begin
        if (boot_cnt_q == BOOT_W'(BOOT_DELAY - 1)) begin
          boot_fired_q <= 1'b1;
          boot_pend_q  <= 1'b1;
        end else begin
          boot_cnt_q <= boot_cnt_q + 1'b1;
        end
      end
      if (boot_take) boot_pend_q <= 1'b0;
    end
  end
`else
  assign boot_take = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      arp_pend_q    <= 1'b0;
      arp_tx_en_q   <= 1'b0;
      arp_tx_type_q <= 1'b0;
      gmii_tx_en_q  <= 1'b0;
      gmii_txd_q    <= 8'h00;
      tx_error_q    <= 2'b00;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      arp_tx_en_q  <= 1'b0;
      gmii_tx_en_q <= gmii_tx_en_d;
      gmii_txd_q   <= gmii_txd_d;
      if (udp_tx_start_en && !udp_tx_ready) tx_error_q[1] <= 1'b1;
      // Requests arriving while a reply is being launched merge into that reply.
      arp_pend_q <= arp_take ? 1'b0 : (arp_pend_q | arp_req);

      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (udp_take) begin
            state_q <= S_UDP;
          end else if (arp_take) begin
            arp_tx_en_q   <= 1'b1;
            arp_tx_type_q <= 1'b1;
            state_q       <= S_ARP;
          end else if (boot_take) begin
            arp_tx_en_q   <= 1'b1;
            arp_tx_type_q <= 1'b0;
            state_q       <= S_ARP;
          end
        end
        S_ARP, S_UDP: begin
          if (owner_done) begin
            state_q <= S_GAP;
            cnt_q   <= '0;
          end else if (timeout) begin
            state_q       <= S_GAP;
            cnt_q         <= '0;
            tx_error_q[0] <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_GAP: begin
          if (cnt_q == CNT_W'(IFG_CYCLES - 1)) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign arp_tx_en   = arp_tx_en_q;
  assign arp_tx_type = arp_tx_type_q;
  assign gmii_tx_en  = gmii_tx_en_q;
  assign gmii_txd    = gmii_txd_q;
  assign tx_error    = tx_error_q;

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Self-checking bench for eth_tx_arbiter: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a port-ownership model.
module tb_eth_tx_arbiter;

  localparam int IFG = 12;
  localparam int TMO = 4095;
`ifdef ARP_BOOT_REQ_EN
  localparam int BOOT = 100;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       arp_rx_done, arp_rx_type, arp_tx_done, arp_gmii_tx_en;
  logic [7:0] arp_gmii_txd;
  logic       udp_tx_start_en, udp_tx_done, udp_gmii_tx_en;
  logic [7:0] udp_gmii_txd;
  logic       arp_tx_en, arp_tx_type, udp_tx_ready, gmii_tx_en;
  logic [7:0] gmii_txd;
  logic [1:0] tx_error;

  always #4 clk = ~clk;

  eth_tx_arbiter #(
    .IFG_CYCLES(IFG),
    .TX_TIMEOUT(TMO)
`ifdef ARP_BOOT_REQ_EN
    ,
    .BOOT_DELAY(BOOT)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .arp_rx_done(arp_rx_done), .arp_rx_type(arp_rx_type),
    .arp_tx_en(arp_tx_en), .arp_tx_type(arp_tx_type), .arp_tx_done(arp_tx_done),
    .arp_gmii_tx_en(arp_gmii_tx_en), .arp_gmii_txd(arp_gmii_txd),
    .udp_tx_start_en(udp_tx_start_en), .udp_tx_done(udp_tx_done),
    .udp_gmii_tx_en(udp_gmii_tx_en), .udp_gmii_txd(udp_gmii_txd),
    .udp_tx_ready(udp_tx_ready), .gmii_tx_en(gmii_tx_en), .gmii_txd(gmii_txd),
    .tx_error(tx_error)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: who owns the port, how long it has held it, how much gap is left.
  typedef enum {OWN_NONE, OWN_ARP, OWN_UDP, OWN_GAP} own_e;
  own_e       m_own;
  int         m_age, m_gap_left, m_boot_clock;
  bit         m_pend, m_arp_en, m_arp_type, m_en, m_boot_pend, m_boot_fired;
  logic [7:0] m_d;
  bit   [1:0] m_err;
  bit         model_on = 1'b0;

  task automatic model_step();
    bit take_udp, take_arp, take_boot, done;
    if (!rst_n) begin
      m_own = OWN_NONE; m_age = 0; m_gap_left = 0; m_pend = 0;
      m_arp_en = 0; m_arp_type = 0; m_en = 0; m_d = 8'h00; m_err = 2'b00;
      m_boot_clock = 0; m_boot_pend = 0; m_boot_fired = 0;
      return;
    end
    if (m_own == OWN_ARP) begin
      m_en = arp_gmii_tx_en; m_d = arp_gmii_txd;
    end else if (m_own == OWN_UDP || (m_own == OWN_NONE && udp_tx_start_en)) begin
      m_en = udp_gmii_tx_en; m_d = udp_gmii_txd;
    end else begin
      m_en = 0; m_d = 8'h00;
    end
    if (udp_tx_start_en && m_own != OWN_NONE) m_err[1] = 1'b1;
    take_udp  = (m_own == OWN_NONE) && udp_tx_start_en;
    take_arp  = (m_own == OWN_NONE) && !udp_tx_start_en && m_pend;
    take_boot = (m_own == OWN_NONE) && !udp_tx_start_en && !m_pend && m_boot_pend;
    m_arp_en  = take_arp || take_boot;
    if (take_arp)  m_arp_type = 1'b1;
    if (take_boot) m_arp_type = 1'b0;
    case (m_own)
      OWN_NONE: begin
        if (take_udp) begin m_own = OWN_UDP; m_age = 1; end
        else if (take_arp || take_boot) begin m_own = OWN_ARP; m_age = 1; end
      end
      OWN_ARP, OWN_UDP: begin
        done = (m_own == OWN_ARP) ? arp_tx_done : udp_tx_done;
        if (done) begin
          m_own = OWN_GAP; m_gap_left = IFG;
        end else if (m_age == TMO) begin
          m_own = OWN_GAP; m_gap_left = IFG; m_err[0] = 1'b1;
        end else begin
          m_age++;
        end
      end
      default: begin
        m_gap_left--;
        if (m_gap_left == 0) m_own = OWN_NONE;
      end
    endcase
    if (take_arp) m_pend = 1'b0;
    else if (arp_rx_done && !arp_rx_type) m_pend = 1'b1;
`ifdef ARP_BOOT_REQ_EN
    if (take_boot) m_boot_pend = 1'b0;
    if (!m_boot_fired) begin
      m_boot_clock++;
      if (m_boot_clock == BOOT) begin m_boot_fired = 1'b1; m_boot_pend = 1'b1; end
    end
`endif
  endtask

  always @(posedge clk) model_step();

  always @(negedge clk) begin
    if (model_on)
      check("cycle {rdy,aen,atyp,en,txd,err}",
            {18'd0, udp_tx_ready, arp_tx_en, arp_tx_type, gmii_tx_en, gmii_txd, tx_error},
            {18'd0, m_own == OWN_NONE, m_arp_en, m_arp_type, m_en, m_d, m_err});
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!udp_tx_ready && n < 100) begin cyc(); n++; end
    check("wait idle", udp_tx_ready, 1);
  endtask

  initial begin
    int n, pulses;
    rst_n = 0; arp_rx_done = 0; arp_rx_type = 0; arp_tx_done = 0;
    arp_gmii_tx_en = 0; arp_gmii_txd = 0; udp_tx_start_en = 0; udp_tx_done = 0;
    udp_gmii_tx_en = 0; udp_gmii_txd = 0;
    cyc();
    model_on = 1'b1;
    cyc(3);
    check("reset gmii_tx_en", gmii_tx_en, 0);
    check("reset gmii_txd", gmii_txd, 8'h00);
    check("reset arp_tx_en", arp_tx_en, 0);
    check("reset arp_tx_type", arp_tx_type, 0);
    check("reset tx_error", tx_error, 2'b00);
    check("reset udp_tx_ready", udp_tx_ready, 1);
    rst_n = 1;

`ifdef ARP_BOOT_REQ_EN
    n = 0;
    while (!arp_tx_en && n < 300) begin cyc(); n++; end
    check("boot request delay", n, BOOT + 1);
    check("boot request type", arp_tx_type, 0);
    arp_tx_done = 1; cyc(); arp_tx_done = 0;
    wait_idle();
    pulses = 0;
    repeat (200) begin cyc(); if (arp_tx_en) pulses++; end
    check("boot request once", pulses, 0);
`endif

    // ARP request answered with a reply frame.
    arp_rx_done = 1; arp_rx_type = 0; cyc(); arp_rx_done = 0;
    cyc();
    check("reply pulse", arp_tx_en, 1);
    check("reply type", arp_tx_type, 1);
    check("ready low in ARP", udp_tx_ready, 0);
    arp_gmii_tx_en = 1; arp_gmii_txd = 8'h55; cyc();
    check("reply pulse width", arp_tx_en, 0);
    check("arp byte en", gmii_tx_en, 1);
    check("arp byte", gmii_txd, 8'h55);
    cyc(2);
    arp_gmii_tx_en = 0; arp_gmii_txd = 8'h00; cyc();
    check("arp stream end", gmii_tx_en, 0);
    arp_tx_done = 1; cyc(); arp_tx_done = 0;
    n = 0;
    while (!udp_tx_ready && n < 50) begin cyc(); n++; end
    check("gap length after ARP", n, IFG);

    // UDP start wins over a pending reply; the reply follows the gap.
    arp_rx_done = 1; cyc(); arp_rx_done = 0;
    udp_tx_start_en = 1; udp_gmii_tx_en = 1; udp_gmii_txd = 8'hA1; cyc();
    udp_tx_start_en = 0;
    check("udp first byte", gmii_txd, 8'hA1);
    check("udp first en", gmii_tx_en, 1);
    check("no reply during udp start", arp_tx_en, 0);
    udp_gmii_txd = 8'hA2; cyc();
    check("udp second byte", gmii_txd, 8'hA2);
    udp_gmii_tx_en = 0; udp_gmii_txd = 8'h00; cyc();
    udp_tx_done = 1; cyc(); udp_tx_done = 0;
    n = 0;
    while (!arp_tx_en && n < 60) begin cyc(); n++; end
    check("reply delay after udp_tx_done", n, IFG + 1);
    check("deferred reply type", arp_tx_type, 1);

    // UDP start during ARP flags a collision without disturbing the ARP stream.
    arp_gmii_tx_en = 1; arp_gmii_txd = 8'h55; udp_tx_start_en = 1; cyc();
    udp_tx_start_en = 0;
    check("collision error", tx_error, 2'b10);
    check("collision keeps state", udp_tx_ready, 0);
    check("collision arp byte", gmii_txd, 8'h55);
    cyc();
    check("arp continues", gmii_tx_en, 1);
    arp_gmii_tx_en = 0; arp_gmii_txd = 8'h00; cyc();
    arp_tx_done = 1; cyc(); arp_tx_done = 0;
    wait_idle();

    // Watchdog: UDP frame never reports done.
    udp_tx_start_en = 1; cyc(); udp_tx_start_en = 0;
    n = 0;
    while (!tx_error[0] && n < 5000) begin cyc(); n++; end
    check("watchdog cycles", n, TMO);
    n = 0;
    while (!udp_tx_ready && n < 50) begin cyc(); n++; end
    check("gap after watchdog", n, IFG);
    check("sticky errors", tx_error, 2'b11);

    // Reset in the middle of a UDP frame drops outputs and the pending request.
    udp_gmii_tx_en = 1; udp_gmii_txd = 8'h77; udp_tx_start_en = 1; cyc();
    udp_tx_start_en = 0;
    check("udp byte before reset", gmii_txd, 8'h77);
    arp_rx_done = 1; arp_rx_type = 0; cyc(); arp_rx_done = 0;
    rst_n = 0; cyc();
    check("reset drops gmii_tx_en", gmii_tx_en, 0);
    check("reset clears tx_error", tx_error, 2'b00);
    check("reset restores ready", udp_tx_ready, 1);
    rst_n = 1; udp_gmii_tx_en = 0; udp_gmii_txd = 8'h00;
    pulses = 0;
    repeat (20) begin cyc(); if (arp_tx_en) pulses++; end
    check("pending request lost", pulses, 0);

    // Randomized traffic, checked every cycle by the model.
    repeat (6000) begin
      arp_rx_done     = ($urandom_range(0, 19) == 0);
      arp_rx_type     = 1'($urandom_range(0, 1));
      udp_tx_start_en = ($urandom_range(0, 29) == 0);
      arp_tx_done     = ($urandom_range(0, 24) == 0);
      udp_tx_done     = ($urandom_range(0, 24) == 0);
      arp_gmii_tx_en  = 1'($urandom_range(0, 1));
      arp_gmii_txd    = 8'($urandom_range(0, 255));
      udp_gmii_tx_en  = 1'($urandom_range(0, 1));
      udp_gmii_txd    = 8'($urandom_range(0, 255));
      rst_n           = ($urandom_range(0, 999) != 0);
      cyc();
    end
    rst_n = 1; arp_rx_done = 0; udp_tx_start_en = 0; arp_tx_done = 0; udp_tx_done = 0;
    cyc(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
